commit_unit: RTL and testbench

- In-order retirement stage directly downstream of the ROB.
- Consumes the ROB head entry and its ready flag, and writes the architectural register file for non-store instructions.
- Drives a valid/ack store port to data memory for stores, and tells the ROB when to pop the head.
- Reports the retired ROB tag so the map table can clear stale mappings, and keeps retirement counters.

---
 rtl/commit_unit.sv | 147 ++++++++++++++
 tb/tb_commit_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | commit_unit: in-order retirement of the ROB head (RF write / store port) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 4
`endif

package commit_unit_pkg;
    localparam int XLEN_W = `XLEN;
    localparam int TAG_W  = `ROB_TAG_LEN;

    typedef struct packed {
        logic              valid;
        logic              wr_mem;
        logic [4:0]        dest_reg;
        logic [XLEN_W-1:0] dest_addr;
        logic [XLEN_W-1:0] value;
        logic              store_dep;
        logic              value_ready;
        logic              address_ready;
    } rob_entry_t;
endpackage

module commit_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  commit_unit_pkg::rob_entry_t  head_entry,
    input  logic                         head_ready,
    input  logic [`ROB_TAG_LEN-1:0]      head_tag,
    input  logic                         commit_stall,
    input  logic                         mem_ack,
    output logic                         commit_pop,
    output logic                         rf_wr_en,
    output logic [4:0]                   rf_wr_idx,
    output logic [`XLEN-1:0]             rf_wr_data,
    output logic                         retire_valid,
    output logic [`ROB_TAG_LEN-1:0]      retire_tag,
    output logic                         mem_store_req,
    output logic [`XLEN-1:0]             mem_store_addr,
    output logic [`XLEN-1:0]             mem_store_data,
    output logic [CNT_WIDTH-1:0]         retired_count,
    output logic [CNT_WIDTH-1:0]         store_count
);

    localparam logic [0:0]           c_IDLE     = 1'b0;
    localparam logic [0:0]           c_STORE    = 1'b1;
    localparam logic [4:0]           c_ZERO_REG = 5'd0;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]              r_state;
    logic [0:0]              w_next_state;
    logic                    w_eligible;
    logic                    w_alu_commit;
    logic                    w_store_issue;
    logic                    w_store_done;
    logic [`ROB_TAG_LEN-1:0] r_store_tag;
    logic                    w_unused;

    // Readiness is already folded into head_ready; these fields are informational here.
    assign w_unused = &{1'b0, head_entry.store_dep, head_entry.value_ready,
                        head_entry.address_ready};

    assign w_eligible = head_entry.valid && head_ready && !commit_stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_eligible && head_entry.wr_mem) w_next_state = c_STORE;
            c_STORE: if (mem_ack) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_alu_commit  = 1'b0;
        w_store_issue = 1'b0;
        w_store_done  = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_alu_commit  = w_eligible && !head_entry.wr_mem;
                w_store_issue = w_eligible &&  head_entry.wr_mem;
            end
            c_STORE: w_store_done = mem_ack;
            default: ;
        endcase
        // Gated by reset so the ROB never advances while the unit is held in reset.
        commit_pop = reset && (w_alu_commit || w_store_done);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_wr_en       <= 1'b0;
            rf_wr_idx      <= '0;
            rf_wr_data     <= '0;
            retire_valid   <= 1'b0;
            retire_tag     <= '0;
            mem_store_req  <= 1'b0;
            mem_store_addr <= '0;
            mem_store_data <= '0;
            r_store_tag    <= '0;
            retired_count  <= '0;
            store_count    <= '0;
        end else begin
            rf_wr_en     <= 1'b0;
            retire_valid <= 1'b0;
            if (w_alu_commit) begin
                rf_wr_en      <= (head_entry.dest_reg != c_ZERO_REG);
                rf_wr_idx     <= head_entry.dest_reg;
                rf_wr_data    <= head_entry.value;
                retire_valid  <= 1'b1;
                retire_tag    <= head_tag;
                retired_count <= retired_count + c_CNT_ONE;
            end
            if (w_store_issue) begin
                mem_store_req  <= 1'b1;
                mem_store_addr <= head_entry.dest_addr;
                mem_store_data <= head_entry.value;
                r_store_tag    <= head_tag;
            end
            if (w_store_done) begin
                mem_store_req <= 1'b0;
                retire_valid  <= 1'b1;
                retire_tag    <= r_store_tag;
                retired_count <= retired_count + c_CNT_ONE;
                store_count   <= store_count + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_commit_unit: directed vector bench for commit_unit                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_commit_unit;
    import commit_unit_pkg::*;

    logic              clock;
    logic              reset;
    rob_entry_t        head_entry;
    logic              head_ready;
    logic [TAG_W-1:0]  head_tag;
    logic              commit_stall;
    logic              mem_ack;
    logic              commit_pop;
    logic              rf_wr_en;
    logic [4:0]        rf_wr_idx;
    logic [XLEN_W-1:0] rf_wr_data;
    logic              retire_valid;
    logic [TAG_W-1:0]  retire_tag;
    logic              mem_store_req;
    logic [XLEN_W-1:0] mem_store_addr;
    logic [XLEN_W-1:0] mem_store_data;
    logic [31:0]       retired_count;
    logic [31:0]       store_count;

    commit_unit #(.CNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .head_entry(head_entry), .head_ready(head_ready),
        .head_tag(head_tag), .commit_stall(commit_stall), .mem_ack(mem_ack),
        .commit_pop(commit_pop), .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx),
        .rf_wr_data(rf_wr_data), .retire_valid(retire_valid), .retire_tag(retire_tag),
        .mem_store_req(mem_store_req), .mem_store_addr(mem_store_addr),
        .mem_store_data(mem_store_data), .retired_count(retired_count),
        .store_count(store_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic [4:0]  dest;
        logic [31:0] value;
        logic [3:0]  tag;
        logic        ready;
        logic        stall;
        logic        e_pop;
        logic        e_wr_en;
        logic [4:0]  e_idx;
        logic [31:0] e_data;
        logic        e_rv;
        logic [3:0]  e_tag;
    } vec_t;

    vec_t        vecs [8];
    int          n_pass;
    int          n_total;
    int          exp_ret;
    int          exp_st;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_head(input logic v, input logic wm, input logic [4:0] dr,
                            input logic [31:0] addr, input logic [31:0] val,
                            input logic [3:0] tag, input logic rdy, input logic stall);
        head_entry           = '0;
        head_entry.valid     = v;
        head_entry.wr_mem    = wm;
        head_entry.dest_reg  = dr;
        head_entry.dest_addr = addr;
        head_entry.value     = val;
        head_tag             = tag;
        head_ready           = rdy;
        commit_stall         = stall;
    endtask

    initial begin
        n_pass = 0; n_total = 0; exp_ret = 0; exp_st = 0;
        //        valid dest  value          tag ready stall | pop en idx data          rv tag
        vecs[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 4'd2};
        vecs[1] = '{1'b1, 5'd0, 32'h7,         4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h7,         1'b1, 4'd3};
        vecs[2] = '{1'b1, 5'd8, 32'h99,        4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h7,         1'b0, 4'd3};
        vecs[3] = '{1'b0, 5'd8, 32'h99,        4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h7,         1'b0, 4'd3};
        vecs[4] = '{1'b1, 5'd8, 32'h99,        4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h7,         1'b0, 4'd3};
        vecs[5] = '{1'b1, 5'd1, 32'h1111,      4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h1111,      1'b1, 4'd4};
        vecs[6] = '{1'b1, 5'd2, 32'h2222,      4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h2222,      1'b1, 4'd5};
        vecs[7] = '{1'b1, 5'd3, 32'h3333,      4'd6, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h3333,      1'b1, 4'd6};

        reset = 1'b0;
        mem_ack = 1'b0;
        set_head(1'b1, 1'b0, 5'd4, 32'h0, 32'h1, 4'd1, 1'b1, 1'b0);
        #1;
        check("reset_pop", commit_pop, 0);
        check("reset_rf_wr_en", rf_wr_en, 0);
        check("reset_retire_valid", retire_valid, 0);
        check("reset_store_req", mem_store_req, 0);
        check("reset_retired_count", retired_count, 0);
        check("reset_store_count", store_count, 0);

        @(negedge clock);
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            set_head(vecs[i].valid, 1'b0, vecs[i].dest, 32'h0, vecs[i].value,
                     vecs[i].tag, vecs[i].ready, vecs[i].stall);
            #1;
            check($sformatf("v%0d_pop", i), commit_pop, vecs[i].e_pop);
            @(posedge clock);
            #1;
            if (vecs[i].e_pop) exp_ret++;
            check($sformatf("v%0d_wr_en", i), rf_wr_en, vecs[i].e_wr_en);
            check($sformatf("v%0d_wr_idx", i), rf_wr_idx, vecs[i].e_idx);
            check($sformatf("v%0d_wr_data", i), rf_wr_data, vecs[i].e_data);
            check($sformatf("v%0d_retire_valid", i), retire_valid, vecs[i].e_rv);
            check($sformatf("v%0d_retire_tag", i), retire_tag, vecs[i].e_tag);
            check($sformatf("v%0d_retired_count", i), retired_count, exp_ret);
        end

        // mem_ack while idle must not retire anything
        @(negedge clock);
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
        mem_ack = 1'b1;
        #1;
        check("idle_ack_pop", commit_pop, 0);
        @(posedge clock);
        #1;
        check("idle_ack_store_count", store_count, exp_st);
        check("idle_ack_retire_valid", retire_valid, 0);

        // Store with a 3-cycle ack delay, stall and head_ready toggled meanwhile
        @(negedge clock);
        mem_ack = 1'b0;
        set_head(1'b1, 1'b1, 5'd0, 32'h100, 32'h55, 4'd1, 1'b1, 1'b0);
        #1;
        check("st_issue_pop", commit_pop, 0);
        @(posedge clock);
        #1;
        check("st_req", mem_store_req, 1);
        check("st_addr", mem_store_addr, 32'h100);
        check("st_data", mem_store_data, 32'h55);
        check("st_issue_rv", retire_valid, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            commit_stall = 1'b1;
            head_ready   = 1'b0;
            #1;
            check($sformatf("st_wait%0d_pop", c), commit_pop, 0);
            @(posedge clock);
            #1;
            check($sformatf("st_wait%0d_req", c), mem_store_req, 1);
            check($sformatf("st_wait%0d_addr", c), mem_store_addr, 32'h100);
            check($sformatf("st_wait%0d_data", c), mem_store_data, 32'h55);
            check($sformatf("st_wait%0d_retired", c), retired_count, exp_ret);
        end
        @(negedge clock);
        mem_ack = 1'b1;
        #1;
        check("st_ack_pop", commit_pop, 1);
        @(posedge clock);
        #1;
        exp_ret++; exp_st++;
        check("st_done_req", mem_store_req, 0);
        check("st_done_rv", retire_valid, 1);
        check("st_done_tag", retire_tag, 1);
        check("st_done_wr_en", rf_wr_en, 0);
        check("st_done_retired", retired_count, exp_ret);
        check("st_done_stores", store_count, exp_st);

        // Async reset in the middle of a store
        @(negedge clock);
        mem_ack = 1'b0;
        set_head(1'b1, 1'b1, 5'd0, 32'h200, 32'h66, 4'd6, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        check("rst_st_req", mem_store_req, 1);
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
        #2;
        mem_ack = 1'b1;
        reset   = 1'b0;
        #1;
        check("rst_mid_req", mem_store_req, 0);
        check("rst_mid_pop", commit_pop, 0);
        check("rst_mid_retired", retired_count, 0);
        check("rst_mid_stores", store_count, 0);
        @(negedge clock);
        reset   = 1'b1;
        mem_ack = 1'b0;
        set_head(1'b1, 1'b0, 5'd9, 32'h0, 32'h1234, 4'd7, 1'b1, 1'b0);
        #1;
        check("post_rst_pop", commit_pop, 1);
        @(posedge clock);
        #1;
        check("post_rst_wr_en", rf_wr_en, 1);
        check("post_rst_idx", rf_wr_idx, 9);
        check("post_rst_tag", retire_tag, 7);
        check("post_rst_retired", retired_count, 1);
        check("post_rst_req", mem_store_req, 0);

        @(negedge clock);
        set_head(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
